paddle_tracker: RTL and testbench

- Sits directly downstream of the dual-channel ADC interface in the Ping-Pong design.
- Consumes the two 8-bit potentiometer readings (DATA_AD0, DATA_AD1) each time a conversion completes, i.e. on the BUSY falling edge.
- Smooths each channel with a 4-sample moving average, maps it to a vertical paddle coordinate, and applies deadband hysteresis.
- Publishes both paddle positions with a one-cycle valid strobe and an input-stale flag for the game logic.

---
 rtl/ping_pong_pkg.sv | 24 ++
 rtl/busy_edge_sync.sv | 35 +++
 rtl/paddle_tracker.sv | 171 +++++++++++++++++
 tb/tb_paddle_tracker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ping_pong_pkg.sv
// Shared types and constants for the Ping-Pong design: data widths, screen
// geometry and the paddle tracker state encoding.
package ping_pong_pkg;

    localparam int ADC_W       = 8;
    localparam int POS_W       = 10;
    localparam int SCREEN_H    = 480;
    localparam int PADDLE_H    = 60;
    localparam int Y_RANGE_DEF = SCREEN_H - PADDLE_H;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        CALC0,
        CALC1,
        UPDATE
    } tracker_state_e;

    function automatic logic [POS_W-1:0] abs_diff(input logic [POS_W-1:0] a,
                                                  input logic [POS_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/busy_edge_sync.sv
// Two-flop synchroniser plus history flop; emits a one-cycle event on the
// falling edge of a strobe generated in another clock domain.
module busy_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic strobe_in,
    output logic fall_ev
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic hist_q, hist_d;

    always_comb begin
        meta_d = strobe_in;
        sync_d = meta_q;
        hist_d = sync_q;
    end

    // Clearing to 0 means a strobe already low at reset release is never seen as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign fall_ev = hist_q & ~sync_q;

endmodule

// File: rtl/paddle_tracker.sv
// Turns two potentiometer ADC readings into smoothed, deadbanded paddle
// coordinates, with a per-update valid strobe, stale-input and overrun flags.
module paddle_tracker
    import ping_pong_pkg::*;
#(
    parameter int Y_RANGE  = Y_RANGE_DEF,
    parameter int DEADBAND = 2,
    parameter int TIMEOUT  = 500000,
    parameter bit INVERT   = 1'b0
) (
    input  logic             CLOCK_50MHz,
    input  logic             RESET,
    input  logic             BUSY,
    input  logic [ADC_W-1:0] DATA_AD0,
    input  logic [ADC_W-1:0] DATA_AD1,
    output logic [POS_W-1:0] PADDLE0_Y,
    output logic [POS_W-1:0] PADDLE1_Y,
    output logic             POS_VALID,
    output logic             STALE,
    output logic             OVERRUN
);

    localparam int SUM_W  = ADC_W + 2;
    localparam int PROD_W = ADC_W + POS_W;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [POS_W-1:0] Y_MID   = POS_W'(Y_RANGE >> 1);
    localparam logic [POS_W-1:0] Y_MUL   = POS_W'(Y_RANGE);
    localparam logic [POS_W-1:0] MAP_MAX = POS_W'((255 * Y_RANGE) >> 8);
    localparam logic [POS_W-1:0] DB      = POS_W'(DEADBAND);

    logic             ev;
    logic [ADC_W-1:0] in0, in1;

    tracker_state_e              state_q, state_d;
    logic [ADC_W-1:0]            hold0_q, hold0_d, hold1_q, hold1_d;
    logic [3:0][ADC_W-1:0]       win0_q, win0_d, win1_q, win1_d;
    logic                        primed_q, primed_d;
    logic [POS_W-1:0]            cand0_q, cand0_d, cand1_q, cand1_d;
    logic [POS_W-1:0]            pad0_q, pad0_d, pad1_q, pad1_d;
    logic                        pos_valid_q, pos_valid_d;
    logic                        overrun_q, overrun_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic [3:0][ADC_W-1:0]       sel_win;
    logic [POS_W-1:0]            sel_cur;
    logic [SUM_W-1:0]            sum;
    logic [ADC_W-1:0]            avg;
    logic [PROD_W-1:0]           product;
    logic [POS_W-1:0]            mapped;
    logic                        take;
    logic [POS_W-1:0]            next_cand;

    busy_edge_sync u_busy_sync (
        .clk       (CLOCK_50MHz),
        .rst       (RESET),
        .strobe_in (BUSY),
        .fall_ev   (ev)
    );

    assign in0 = INVERT ? ~DATA_AD0 : DATA_AD0;
    assign in1 = INVERT ? ~DATA_AD1 : DATA_AD1;

    // Single datapath with one multiplier, steered to channel 1 only in CALC1.
    always_comb begin
        sel_win   = (state_q == CALC1) ? win1_q : win0_q;
        sel_cur   = (state_q == CALC1) ? pad1_q : pad0_q;
        sum       = SUM_W'(sel_win[0]) + SUM_W'(sel_win[1])
                  + SUM_W'(sel_win[2]) + SUM_W'(sel_win[3]);
        avg       = sum[SUM_W-1:2];
        product   = PROD_W'(avg) * PROD_W'(Y_MUL);
        mapped    = product[PROD_W-1:ADC_W];
        take      = (abs_diff(mapped, sel_cur) > DB) || (mapped == '0) || (mapped == MAP_MAX);
        next_cand = take ? mapped : sel_cur;
    end

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        hold0_d     = hold0_q;
        hold1_d     = hold1_q;
        win0_d      = win0_q;
        win1_d      = win1_q;
        primed_d    = primed_q;
        cand0_d     = cand0_q;
        cand1_d     = cand1_q;
        pad0_d      = pad0_q;
        pad1_d      = pad1_q;
        pos_valid_d = 1'b0;
        overrun_d   = overrun_q | (ev && (state_q != IDLE));
        cnt_d       = ev ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);

        case (state_q)
            IDLE: begin
                if (ev) begin
                    hold0_d = in0;
                    hold1_d = in1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (primed_q) begin
                    win0_d = {win0_q[2:0], hold0_q};
                    win1_d = {win1_q[2:0], hold1_q};
                end else begin
                    win0_d = {4{hold0_q}};
                    win1_d = {4{hold1_q}};
                end
                primed_d = 1'b1;
                state_d  = CALC0;
            end
            CALC0: begin
                cand0_d = next_cand;
                state_d = CALC1;
            end
            CALC1: begin
                cand1_d = next_cand;
                state_d = UPDATE;
            end
            UPDATE: begin
                pad0_d      = cand0_q;
                pad1_d      = cand1_q;
                pos_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the sample windows are reset too, so a reset mid-stream cannot leak old samples.
    always_ff @(posedge CLOCK_50MHz) begin
        if (RESET) begin
            state_q     <= IDLE;
            hold0_q     <= '0;
            hold1_q     <= '0;
            win0_q      <= '0;
            win1_q      <= '0;
            primed_q    <= 1'b0;
            cand0_q     <= Y_MID;
            cand1_q     <= Y_MID;
            pad0_q      <= Y_MID;
            pad1_q      <= Y_MID;
            pos_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q     <= state_d;
            hold0_q     <= hold0_d;
            hold1_q     <= hold1_d;
            win0_q      <= win0_d;
            win1_q      <= win1_d;
            primed_q    <= primed_d;
            cand0_q     <= cand0_d;
            cand1_q     <= cand1_d;
            pad0_q      <= pad0_d;
            pad1_q      <= pad1_d;
            pos_valid_q <= pos_valid_d;
            overrun_q   <= overrun_d;
            cnt_q       <= cnt_d;
        end
    end

    assign PADDLE0_Y = pad0_q;
    assign PADDLE1_Y = pad1_q;
    assign POS_VALID = pos_valid_q;
    assign STALE     = (cnt_q == CNT_MAX);
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_paddle_tracker.sv
// Directed bench for paddle_tracker: one instance with a short timeout, one
// with inverted inputs; expected coordinates are hand-computed for Y_RANGE=420.
module tb_paddle_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       busy_a, busy_b;
    logic [7:0] ad0_a, ad1_a, ad0_b, ad1_b;
    logic [9:0] p0_a, p1_a, p0_b, p1_b;
    logic       pv_a, st_a, ov_a, pv_b, st_b, ov_b;

    int n_checks = 0;
    int n_bad    = 0;

    paddle_tracker #(.TIMEOUT(100)) dut_a (
        .CLOCK_50MHz (clk),
        .RESET       (rst),
        .BUSY        (busy_a),
        .DATA_AD0    (ad0_a),
        .DATA_AD1    (ad1_a),
        .PADDLE0_Y   (p0_a),
        .PADDLE1_Y   (p1_a),
        .POS_VALID   (pv_a),
        .STALE       (st_a),
        .OVERRUN     (ov_a)
    );

    paddle_tracker #(.INVERT(1'b1)) dut_b (
        .CLOCK_50MHz (clk),
        .RESET       (rst),
        .BUSY        (busy_b),
        .DATA_AD0    (ad0_b),
        .DATA_AD1    (ad1_b),
        .PADDLE0_Y   (p0_b),
        .PADDLE1_Y   (p1_b),
        .POS_VALID   (pv_b),
        .STALE       (st_b),
        .OVERRUN     (ov_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One conversion on dut_a: BUSY falls now; valid is expected 7 clocks later
    // (2 synchroniser clocks, then CAPTURE/CALC0/CALC1/UPDATE, then the strobe).
    task automatic convert_a(input logic [7:0] a0, input logic [7:0] a1,
                             output int lat, output int pulses,
                             output logic st2, output logic st3);
        ad0_a  = a0;
        ad1_a  = a1;
        busy_a = 1'b0;
        lat    = -1;
        pulses = 0;
        st2    = 1'b0;
        st3    = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (pv_a) begin
                pulses++;
                if (lat < 0) lat = i;
            end
            if (i == 2) st2 = st_a;
            if (i == 3) st3 = st_a;
        end
        busy_a = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic step_a(input string tag, input logic [7:0] a0, input logic [7:0] a1,
                          input int exp0, input int exp1);
        int   lat, pulses;
        logic st2, st3;
        convert_a(a0, a1, lat, pulses, st2, st3);
        check({tag, ".latency"}, lat, 7);
        check({tag, ".pulses"}, pulses, 1);
        check({tag, ".p0"}, p0_a, exp0);
        check({tag, ".p1"}, p1_a, exp1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, pulses, first;
        logic st2, st3;

        rst    = 1'b1;
        busy_a = 1'b1;
        busy_b = 1'b1;
        ad0_a  = '0;
        ad1_a  = '0;
        ad0_b  = '0;
        ad1_b  = '0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        check("reset.p0", p0_a, 210);
        check("reset.p1", p1_a, 210);
        check("reset.pos_valid", pv_a, 0);
        check("reset.stale", st_a, 0);
        check("reset.overrun", ov_a, 0);
        check("reset.b_p0", p0_b, 210);

        // Prefill: 200 -> 84000>>8 = 328; 0 hits the low-extreme rule.
        step_a("first", 8'd200, 8'd0, 328, 0);

        // Window averages 150, 100, 50.
        step_a("avg1", 8'd0, 8'd0, 246, 0);
        step_a("avg2", 8'd0, 8'd0, 164, 0);
        step_a("avg3", 8'd0, 8'd0, 82, 0);

        // Window [200,0,0,0] filling with 128: averages 32, 64, 96, 128.
        step_a("ramp1", 8'd128, 8'd0, 52, 0);
        step_a("ramp2", 8'd128, 8'd0, 105, 0);
        step_a("ramp3", 8'd128, 8'd0, 157, 0);
        step_a("ramp4", 8'd128, 8'd0, 210, 0);

        // 129s: mapped 210,210,210,211, all within the deadband.
        step_a("db129_1", 8'd129, 8'd0, 210, 0);
        step_a("db129_2", 8'd129, 8'd0, 210, 0);
        step_a("db129_3", 8'd129, 8'd0, 210, 0);
        step_a("db129_4", 8'd129, 8'd0, 210, 0);

        // 131s: averages 129,130,130,131 -> mapped 211,213,213,214; only 213 clears the deadband.
        step_a("db131_1", 8'd131, 8'd0, 210, 0);
        step_a("db131_2", 8'd131, 8'd0, 213, 0);
        step_a("db131_3", 8'd131, 8'd0, 213, 0);
        step_a("db131_4", 8'd131, 8'd0, 213, 0);

        // Stale: window [131,131,131,0] -> avg 98 -> 160; counter cleared on
        // clock 3 after the fall, reaches 99 on clock 102.
        ad0_a  = 8'd0;
        ad1_a  = 8'd0;
        busy_a = 1'b0;
        lat    = -1;
        first  = -1;
        for (int i = 1; i <= 140; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (pv_a && lat < 0) lat = i;
            if (st_a && first < 0) first = i;
            if (i == 20) busy_a = 1'b1;
        end
        check("stale.latency", lat, 7);
        check("stale.onset", first, 102);
        check("stale.held", st_a, 1);
        check("stale.p0_hold", p0_a, 160);

        // Recovery: window [131,131,0,131] -> still 160.
        convert_a(8'd131, 8'd0, lat, pulses, st2, st3);
        check("recover.stale_before", st2, 1);
        check("recover.stale_after", st3, 0);
        check("recover.latency", lat, 7);
        check("recover.p0", p0_b === p0_b ? p0_a : 10'd0, 160);

        // Inverted instance: 255 -> 0 and 0 -> 255 -> 418; a second BUSY fall
        // lands while the FSM is in CALC1 and must be dropped.
        ad0_b  = 8'd255;
        ad1_b  = 8'd0;
        busy_b = 1'b0;
        lat    = -1;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 2) busy_b = 1'b1;
            if (i == 3) busy_b = 1'b0;
            if (pv_b) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
        check("inv.latency", lat, 7);
        check("inv.pulses", pulses, 1);
        check("inv.p0", p0_b, 0);
        check("inv.p1", p1_b, 418);
        check("inv.overrun", ov_b, 1);
        check("inv.a_no_overrun", ov_a, 0);
        repeat (10) @(negedge clk);
        check("inv.overrun_sticky", ov_b, 1);

        // Reset while dut_a sits in CALC1: the update is abandoned.
        ad0_a  = 8'd100;
        busy_a = 1'b0;
        repeat (5) @(negedge clk);
        rst    = 1'b1;
        busy_a = 1'b1;
        busy_b = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (pv_a) pulses++;
        end
        check("midrst.pulses", pulses, 0);
        check("midrst.p0", p0_a, 210);
        check("midrst.p1", p1_a, 210);
        check("midrst.stale", st_a, 0);
        check("midrst.b_overrun_cleared", ov_b, 0);

        // Re-primed window: 200 -> 328 (an unprimed window would give 82).
        step_a("reprime", 8'd200, 8'd0, 328, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
